key_input_conditioner: RTL and testbench
========================================

Name: key_input_conditioner

Overview:
- Upstream stage of vga_controller: turns raw, bouncy, asynchronous push-button levels into the clean 32-bit controller word the screen FSM consumes.
- Per key: 2-FF synchroniser, stable-time debounce FSM, one-cycle press pulse.
- Pulses replace raw levels, so one physical press advances the screen/slot FSMs exactly once.
- Runs on the VGA pixel clock.

Parameters:
- NUM_KEYS, 4, number of buttons conditioned (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a change (20 ms at 25 MHz); minimum 2.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed.

Ports:
- iVGA_CLK  in  1  sole clock, all state on posedge.
- iRST_n  in  1  reset, asynchronous, active-low.
- key_raw  in  NUM_KEYS  raw button levels, asynchronous to iVGA_CLK.
- controller  out  32  bit i = 1-cycle press pulse for key i; bits [31:NUM_KEYS] tied 0.
- key_level  out  NUM_KEYS  debounced pressed level (1 = held).
- key_release  out  NUM_KEYS  1-cycle pulse on accepted release.

Behaviour:
- Clock/reset: one clock, iVGA_CLK. iRST_n asynchronous assert, active-low.
- During reset:
  - controller, key_level and key_release = 0.
  - All key FSMs in IDLE, counters 0.
  - Synchroniser flops loaded with the "released" level (1 if KEY_ACTIVE_LOW).
- Reset mid-press: all outputs clear immediately. After deassertion a key still held must be re-qualified for the full DEBOUNCE_CYCLES, then pulses once.
- Normalisation: pressed = sync2 XOR KEY_ACTIVE_LOW.
- Synchroniser: 2 flops per key. The raw edge is visible to the FSM 2 cycles after first sampled.
- Per-key FSM, counter width clog2(DEBOUNCE_CYCLES):
  - IDLE: pressed=0 -> stay, cnt=0. pressed=1 -> PRESS_PEND, cnt=1.
  - PRESS_PEND:
    - pressed=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
    - pressed=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, press pulse this edge.
    - Otherwise cnt+1.
  - HELD: pressed=1 -> stay. pressed=0 -> RELEASE_PEND, cnt=1.
  - RELEASE_PEND:
    - pressed=1 -> HELD, cnt=0 (no pulse).
    - pressed=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, release pulse.
    - Otherwise cnt+1.
- Outputs are registered, driven on the edge that enters HELD / IDLE from a PEND state.
  - Pulse width exactly 1 cycle.
  - key_level = 1 in HELD and RELEASE_PEND, 0 otherwise.
- Latency: raw level stable from edge t is first registered at t. controller[i] is high during cycle t+DEBOUNCE_CYCLES+1 only, if no bounce occurred.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Keys are independent:
  - Simultaneous presses give simultaneous pulses on several bits.
  - No priority encoding here; the screen FSM owns priority.
- Holding a key: exactly one press pulse, no auto-repeat.
- Glitches shorter than DEBOUNCE_CYCLES never reach any output.

Decomposition:
- Package key_input_pkg:
  - 2-bit state encoding: KEY_IDLE=0, KEY_PRESS_PEND=1, KEY_HELD=2, KEY_RELEASE_PEND=3.
  - Default DEBOUNCE_CYCLES constant.
  - Controller bit-index constants: BTN_BACK=0, BTN_SAVE=1, BTN_LOAD=2, BTN_PLAY=3. These match the screen FSM's bit meanings.
- Sub-module key_debounce_unit:
  - One key: synchroniser + FSM + counter.
  - Outputs pulse_press, pulse_release, level.
  - Top generates NUM_KEYS instances and zero-extends into controller.

Test Plan (DEBOUNCE_CYCLES=8, NUM_KEYS=4, KEY_ACTIVE_LOW=1):
- Reset: hold iRST_n=0 with key_raw=4'b0000 -> controller=0, key_level=0. Release reset with keys held -> controller=32'h0000000F pulses exactly once, 10 cycles after deassert, then 0 while key_level=4'hF.
- Clean press: key_raw[1] 1->0 at edge t, held -> controller=32'h00000002 during cycle t+9 only. key_level[1]=1 from t+9.
- Bounce: key_raw[2] low 5 cycles, high 2, low steady -> single controller bit-2 pulse, counted from the last falling edge. The 5-cycle glitch alone -> no pulse.
- Release: after a clean press, raise key_raw[1] -> key_release[1] pulse at +9 cycles, key_level[1]=0. A release glitch of 3 cycles -> no release pulse, key_level stays 1.
- Simultaneous: key_raw[0] and key_raw[3] fall on the same edge -> controller=32'h00000009 for one cycle. Holding 1000 cycles -> no further pulses.
- Reset mid-pend: assert iRST_n=0 at cnt=5 in PRESS_PEND -> all outputs 0 immediately. After release with the key still low -> full 8-cycle requalification, one pulse.

Source files
------------

// File: rtl/key_input_pkg.sv
// key_input_pkg
//   Shared definitions for the push-button conditioning front end that feeds
//   the VGA screen FSM.
//   - key_state_e     : per-key debounce state encoding.
//   - DEBOUNCE_CYCLES_DEFAULT : 20 ms of stable level at the 25 MHz pixel clock.
//   - BTN_*           : controller-word bit meanings shared with the screen FSM.
package key_input_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_PEND   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_PEND = 2'd3
  } key_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Bit positions inside the 32-bit controller word.
  localparam int BTN_BACK = 0;
  localparam int BTN_SAVE = 1;
  localparam int BTN_LOAD = 2;
  localparam int BTN_PLAY = 3;

endpackage

// File: rtl/key_debounce_unit.sv
// key_debounce_unit
//   Conditions one raw push-button: 2-FF synchroniser, stable-time debounce
//   FSM with counter, and registered one-cycle press/release pulses.
//   Ports:
//     i_clk           : clock, all state on posedge.
//     i_rst_n         : asynchronous active-low reset.
//     i_key_raw       : raw key level, asynchronous to i_clk.
//     o_pulse_press   : 1-cycle pulse when a press is accepted.
//     o_pulse_release : 1-cycle pulse when a release is accepted.
//     o_level         : debounced pressed level (1 = held).
module key_debounce_unit
  import key_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_pulse_press,
  output logic o_pulse_release,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  key_state_e    r_state;
  key_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_pulse_press;
  logic          r_pulse_release;
  logic          w_press_fire;
  logic          w_release_fire;
  logic          w_pressed;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= KEY_ACTIVE_LOW;
      r_sync2 <= KEY_ACTIVE_LOW;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ KEY_ACTIVE_LOW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= KEY_IDLE;
      r_cnt           <= '0;
      r_pulse_press   <= 1'b0;
      r_pulse_release <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_pulse_press   <= w_press_fire;
      r_pulse_release <= w_release_fire;
    end
  end

  // The counter holds the number of consecutive stable cycles already seen;
  // the change is accepted on the edge where the DEBOUNCE_CYCLES-th stable
  // sample arrives, so it never needs to exceed CNT_LAST.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_fire   = 1'b0;
    w_release_fire = 1'b0;
    case (r_state)
      KEY_IDLE: begin
        if (w_pressed) begin
          w_state_next = KEY_PRESS_PEND;
          w_cnt_next   = CW'(1);
        end else begin
          w_cnt_next   = '0;
        end
      end
      KEY_PRESS_PEND: begin
        if (!w_pressed) begin
          w_state_next = KEY_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = KEY_HELD;
          w_cnt_next   = '0;
          w_press_fire = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      KEY_HELD: begin
        if (w_pressed) begin
          w_cnt_next   = '0;
        end else begin
          w_state_next = KEY_RELEASE_PEND;
          w_cnt_next   = CW'(1);
        end
      end
      KEY_RELEASE_PEND: begin
        if (w_pressed) begin
          w_state_next   = KEY_HELD;
          w_cnt_next     = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = KEY_IDLE;
          w_cnt_next     = '0;
          w_release_fire = 1'b1;
        end else begin
          w_cnt_next     = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = KEY_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_pulse_press   = r_pulse_press;
  assign o_pulse_release = r_pulse_release;
  // A pending release still counts as held until it is accepted.
  assign o_level = (r_state == KEY_HELD) || (r_state == KEY_RELEASE_PEND);

endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Turns raw, bouncy push-button levels into the clean 32-bit controller word
//   consumed by the VGA screen FSM. Each press yields exactly one pulse.
//   Ports:
//     iVGA_CLK    : pixel clock, sole clock.
//     iRST_n      : asynchronous active-low reset.
//     key_raw     : raw button levels, asynchronous to iVGA_CLK.
//     controller  : bit i = 1-cycle press pulse for key i, upper bits 0.
//     key_level   : debounced pressed level per key.
//     key_release : 1-cycle pulse per key on accepted release.
module key_input_conditioner
  import key_input_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [31:0]         controller,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_release
);

  logic [NUM_KEYS-1:0] w_press;

  // Keys are fully independent; any priority is resolved downstream.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce_unit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_key (
        .i_clk           (iVGA_CLK),
        .i_rst_n         (iRST_n),
        .i_key_raw       (key_raw[gi]),
        .o_pulse_press   (w_press[gi]),
        .o_pulse_release (key_release[gi]),
        .o_level         (key_level[gi])
      );
    end
  endgenerate

  assign controller = 32'(w_press);

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_raw;
  logic [31:0] controller;
  logic [3:0]  key_level;
  logic [3:0]  key_release;

  int tests_run;
  int tests_failed;

  key_input_conditioner #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (8),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .key_raw     (key_raw),
    .controller  (controller),
    .key_level   (key_level),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release every key and let all release pendings drain.
  task automatic release_all();
    key_raw = 4'hF;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = 4'h0;
    repeat (3) tick();
    tests_run++;
    if (controller !== 32'h0 || key_level !== 4'h0 || key_release !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_hold controller=%h level=%h release=%h expected 0/0/0",
               controller, key_level, key_release);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (controller !== ((c == 10) ? 32'h0000000F : 32'h0)) begin
        tests_failed++;
        $display("FAIL reset_release_pulse cyc=%0d controller=%h expected=%h",
                 c, controller, (c == 10) ? 32'h0000000F : 32'h0);
      end
    end
    tests_run++;
    if (key_level !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_release_level level=%h expected=f", key_level);
    end
    key_raw = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (key_release !== ((c == 10) ? 4'hF : 4'h0)) begin
        tests_failed++;
        $display("FAIL reset_all_release cyc=%0d release=%h expected=%h",
                 c, key_release, (c == 10) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_clean_press();
    key_raw = 4'b1101;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (controller !== ((c == 10) ? 32'h2 : 32'h0) ||
          key_level !== ((c >= 10) ? 4'b0010 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL clean_press cyc=%0d controller=%h level=%h expected %h/%h",
                 c, controller, key_level, (c == 10) ? 32'h2 : 32'h0,
                 (c >= 10) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_release();
    // Key 1 is held from the clean-press test.
    key_raw = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (key_release !== ((c == 10) ? 4'b0010 : 4'b0000) ||
          key_level !== ((c >= 10) ? 4'b0000 : 4'b0010) ||
          controller !== 32'h0) begin
        tests_failed++;
        $display("FAIL release cyc=%0d release=%h level=%h controller=%h expected %h/%h/0",
                 c, key_release, key_level, controller,
                 (c == 10) ? 4'b0010 : 4'b0000, (c >= 10) ? 4'b0000 : 4'b0010);
      end
    end
    // Re-press, then a 3-cycle release glitch must be absorbed.
    key_raw = 4'b1101;
    repeat (12) tick();
    tests_run++;
    if (key_level !== 4'b0010) begin
      tests_failed++;
      $display("FAIL repress_level level=%h expected=2", key_level);
    end
    key_raw = 4'hF;
    repeat (3) tick();
    key_raw = 4'b1101;
    for (int c = 1; c <= 15; c++) begin
      tick();
      tests_run++;
      if (key_release !== 4'h0 || key_level !== 4'b0010 || controller !== 32'h0) begin
        tests_failed++;
        $display("FAIL release_glitch cyc=%0d release=%h level=%h controller=%h expected 0/2/0",
                 c, key_release, key_level, controller);
      end
    end
    release_all();
  endtask

  task automatic test_bounce();
    // A lone 5-cycle glitch must never produce a pulse.
    key_raw = 4'b1011;
    repeat (5) tick();
    key_raw = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      tick();
      tests_run++;
      if (controller !== 32'h0 || key_level !== 4'h0) begin
        tests_failed++;
        $display("FAIL glitch_only cyc=%0d controller=%h level=%h expected 0/0",
                 c, controller, key_level);
      end
    end
    // Low 5, high 2, then low steady: one pulse timed from the last fall.
    key_raw = 4'b1011;
    repeat (5) tick();
    key_raw = 4'hF;
    repeat (2) tick();
    tests_run++;
    if (controller !== 32'h0) begin
      tests_failed++;
      $display("FAIL bounce_early controller=%h expected=0", controller);
    end
    key_raw = 4'b1011;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (controller !== ((c == 10) ? 32'h4 : 32'h0)) begin
        tests_failed++;
        $display("FAIL bounce_press cyc=%0d controller=%h expected=%h",
                 c, controller, (c == 10) ? 32'h4 : 32'h0);
      end
    end
    release_all();
  endtask

  task automatic test_simultaneous();
    int extra_pulses;
    key_raw = 4'b0110;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (controller !== ((c == 10) ? 32'h9 : 32'h0)) begin
        tests_failed++;
        $display("FAIL simultaneous cyc=%0d controller=%h expected=%h",
                 c, controller, (c == 10) ? 32'h9 : 32'h0);
      end
    end
    extra_pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (controller !== 32'h0) extra_pulses++;
    end
    tests_run++;
    if (extra_pulses != 0 || key_level !== 4'b1001) begin
      tests_failed++;
      $display("FAIL hold_no_repeat pulses=%0d level=%h expected 0/9", extra_pulses, key_level);
    end
    release_all();
  endtask

  task automatic test_reset_mid_pend();
    // Key 3 fully held, key 0 part-way through PRESS_PEND (cnt=5).
    key_raw = 4'b0111;
    repeat (12) tick();
    key_raw = 4'b0110;
    repeat (7) tick();
    tests_run++;
    if (key_level !== 4'b1000 || controller !== 32'h0) begin
      tests_failed++;
      $display("FAIL pre_reset level=%h controller=%h expected 8/0", key_level, controller);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (key_level !== 4'h0 || controller !== 32'h0 || key_release !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_immediate level=%h controller=%h release=%h expected 0/0/0",
               key_level, controller, key_release);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests_run++;
      if (controller !== ((c == 10) ? 32'h9 : 32'h0)) begin
        tests_failed++;
        $display("FAIL requalify cyc=%0d controller=%h expected=%h",
                 c, controller, (c == 10) ? 32'h9 : 32'h0);
      end
    end
    release_all();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    key_raw      = 4'h0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_pend();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
